// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the bit serializer: FSM state encodings and the
// default level driven on the serial line while no word is being shifted.
// No ports (package).
// ---------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10
    } ser_state_e;

    localparam logic SER_IDLE_BIT = 1'b0;

endpackage : ser_pkg

// File: rtl/bit_serializer_if.sv
// ---------------------------------------------------------------------------
// bit_serializer_if
// Bundle of the word handshake and the serial output of bit_serializer.
//   word_in / word_valid / word_ready : parallel word handshake
//   bit_out / bit_valid / last_bit    : serial line towards a bit detector
//   busy                              : shifter active or hold occupied
// Modports:
//   master : word source / serial sink (testbench, upstream logic)
//   slave  : the serializer itself
// ---------------------------------------------------------------------------
interface bit_serializer_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] word_in;
    logic             word_valid;
    logic             word_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             last_bit;
    logic             busy;

    modport master (
        output word_in, word_valid,
        input  word_ready, bit_out, bit_valid, last_bit, busy
    );

    modport slave (
        input  word_in, word_valid,
        output word_ready, bit_out, bit_valid, last_bit, busy
    );

endinterface : bit_serializer_if

// File: rtl/ser_hold_buf.sv
// ---------------------------------------------------------------------------
// ser_hold_buf
// One-entry hold register that parks the next word while the shifter is
// still busy with the current one.
//   clk      : clock, posedge
//   rst      : synchronous active-low reset (clears the full flag only)
//   load     : capture data_in, buffer becomes full
//   drain    : buffer content is taken this edge
//   data_in  : word to park
//   data_out : parked word
//   full     : buffer holds a word
// load and drain on the same edge replace the content and keep full set;
// data_out still shows the old word during that cycle so the drain side
// reads the right value.
// ---------------------------------------------------------------------------
module ser_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load) begin
            data_d = data_in;
            full_d = 1'b1;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload needs no reset: it is only ever read while full_q is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data_out = data_q;
    assign full     = full_q;

endmodule : ser_hold_buf

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial front end for the bit-level sequence detectors. Words
// are taken over a valid/ready handshake and shifted out MSB first, one bit
// per clock, on a registered serial line. A one-entry hold buffer lets the
// next word follow the current one without an idle cycle.
//
// Ports:
//   clk : clock, all logic on posedge
//   rst : synchronous active-low reset
//   ser : bit_serializer_if.slave
//         word_in/word_valid/word_ready  word handshake (ready = hold empty)
//         bit_out/bit_valid/last_bit     registered serial output
//         busy                           shifter active or hold occupied
//
// Optional feature macro: SER_PARITY_EN
//   defined   : an even-parity bit (^word) follows bit 0 of every word and
//               carries last_bit.
//   undefined : words are exactly WIDTH bits, no PARITY state.
// ---------------------------------------------------------------------------
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = SER_IDLE_BIT
) (
    input  logic               clk,
    input  logic               rst,
    bit_serializer_if.slave    ser
);

    localparam int CW = $clog2(WIDTH + 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             last_bit_q, last_bit_d;
    logic             busy_q, busy_d;
    logic             word_ready_q, word_ready_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             accept;
    logic             end_word;
    logic             bypass;
    logic             load_sh;
    logic             hold_load;
    logic             hold_drain;
    logic             hold_full;
    logic             hold_full_next;
    logic [WIDTH-1:0] hold_data;
    logic [WIDTH-1:0] load_word;

    assign accept = ser.word_valid & word_ready_q;

    // end_word: the cycle showing the final bit of a word.
`ifdef SER_PARITY_EN
    assign end_word = (state_q == ST_PARITY);
`else
    assign end_word = (state_q == ST_SHIFT) && (cnt_q == '0);
`endif

    // At the end of a word with nothing parked, an incoming word goes
    // straight into the shifter; otherwise IDLE would see a full hold.
    assign hold_drain     = end_word & hold_full;
    assign bypass         = end_word & ~hold_full & accept;
    assign hold_load      = accept & (state_q != ST_IDLE) & ~bypass;
    assign load_sh        = ((state_q == ST_IDLE) & accept) | hold_drain | bypass;
    assign load_word      = hold_drain ? hold_data : ser.word_in;
    assign hold_full_next = hold_load | (hold_full & ~hold_drain);

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .drain    (hold_drain),
        .data_in  (ser.word_in),
        .data_out (hold_data),
        .full     (hold_full)
    );

    // State register (plus the registered control outputs).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_out_q    <= IDLE_BIT;
            bit_valid_q  <= 1'b0;
            last_bit_q   <= 1'b0;
            busy_q       <= 1'b0;
            word_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            last_bit_q   <= last_bit_d;
            busy_q       <= busy_d;
            word_ready_q <= word_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
`ifdef SER_PARITY_EN
        par_q   <= par_d;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (load_sh) begin
            state_d = ST_SHIFT;
        end else if (end_word) begin
            state_d = ST_IDLE;
`ifdef SER_PARITY_EN
        end else if ((state_q == ST_SHIFT) && (cnt_q == '0)) begin
            state_d = ST_PARITY;
`endif
        end
    end

    // Datapath and output logic. bit_out_q always mirrors the bit that
    // shreg_q[WIDTH-1] held when it was loaded or shifted in.
    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        bit_out_d    = IDLE_BIT;
        bit_valid_d  = 1'b0;
        last_bit_d   = 1'b0;
`ifdef SER_PARITY_EN
        par_d        = par_q;
`endif
        if (load_sh) begin
            shreg_d     = load_word;
            cnt_d       = CW'(WIDTH - 1);
            bit_out_d   = load_word[WIDTH-1];
            bit_valid_d = 1'b1;
`ifdef SER_PARITY_EN
            par_d       = ^load_word;
`endif
        end else if (state_q == ST_SHIFT) begin
            if (cnt_q != '0) begin
                shreg_d     = shreg_q << 1;
                cnt_d       = cnt_q - CW'(1);
                bit_out_d   = shreg_q[WIDTH-2];
                bit_valid_d = 1'b1;
`ifndef SER_PARITY_EN
                last_bit_d  = (cnt_q == CW'(1));
`endif
            end
`ifdef SER_PARITY_EN
            else begin
                bit_out_d   = par_q;
                bit_valid_d = 1'b1;
                last_bit_d  = 1'b1;
            end
`endif
        end
        busy_d       = (state_d != ST_IDLE);
        word_ready_d = ~hold_full_next;
    end

    assign ser.bit_out    = bit_out_q;
    assign ser.bit_valid  = bit_valid_q;
    assign ser.last_bit   = last_bit_q;
    assign ser.busy       = busy_q;
    assign ser.word_ready = word_ready_q;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
// Directed bench for bit_serializer. A queue-based model of the word stream
// predicts every output each cycle; literal expectations pin the serial
// streams of the directed words. Honours SER_PARITY_EN like the design.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    bit_serializer_if #(.WIDTH(W)) bus ();

    bit_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .ser (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: bits still to be shown for the current word, words waiting.
    logic [1:0]   m_bits[$];
    logic [W-1:0] m_pend[$];
    logic         m_valid = 1'b0;
    logic         m_bit   = 1'b0;
    logic         m_last  = 1'b0;
    logic         m_ready = 1'b0;

    // Observed serial stream {bit,last} and the longest gap-free run.
    logic [1:0] cap[$];
    int run    = 0;
    int maxrun = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void expand(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
`ifdef SER_PARITY_EN
            m_bits.push_back({w[i], 1'b0});
`else
            m_bits.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
`endif
        end
`ifdef SER_PARITY_EN
        m_bits.push_back({^w, 1'b1});
`endif
    endfunction

    // Model update on the active edge, from inputs that settled at negedge.
    always @(posedge clk) begin
        logic acc;
        logic used;
        logic [1:0] e;
        if (!rst) begin
            m_bits.delete();
            m_pend.delete();
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_bit   = 1'b0;
            m_last  = 1'b0;
        end else begin
            acc  = bus.word_valid && m_ready;
            used = 1'b0;
            if (m_bits.size() == 0) begin
                if (m_pend.size() > 0) begin
                    expand(m_pend.pop_front());
                end else if (acc) begin
                    expand(bus.word_in);
                    used = 1'b1;
                end
            end
            if (m_bits.size() > 0) begin
                e       = m_bits.pop_front();
                m_bit   = e[1];
                m_last  = e[0];
                m_valid = 1'b1;
            end else begin
                m_bit   = 1'b0;
                m_last  = 1'b0;
                m_valid = 1'b0;
            end
            if (acc && !used) m_pend.push_back(bus.word_in);
            m_ready = (m_pend.size() == 0);
        end
    end

    // Per-cycle compare and stream capture, away from the active edge.
    always @(negedge clk) begin
        chk("bit_valid",  bus.bit_valid,  m_valid);
        chk("bit_out",    bus.bit_out,    m_bit);
        chk("last_bit",   bus.last_bit,   m_last);
        chk("busy",       bus.busy,       m_valid);
        chk("word_ready", bus.word_ready, m_ready);
        if (bus.bit_valid === 1'b1) begin
            cap.push_back({bus.bit_out, bus.last_bit});
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    end

    task automatic clear_cap();
        cap.delete();
        maxrun = 0;
    endtask

    // Present a word until the model says it is taken (bounded).
    task automatic send(input logic [W-1:0] w);
        bit done = 1'b0;
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (m_ready) done = 1'b1;
            @(negedge clk);
        end
        bus.word_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: word %0h not accepted, expected acceptance", w);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!m_valid && m_pend.size() == 0) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: still busy, expected idle");
        end
    endtask

    task automatic check_stream(input string name, input logic [63:0] exp, input int n,
                                input int exp_last, input int exp_run);
        logic [63:0] got = '0;
        int lasts = 0;
        foreach (cap[i]) begin
            got = {got[62:0], cap[i][1]};
            if (cap[i][0]) lasts++;
        end
        chk({name, "_len"},  64'(cap.size()), 64'(n));
        chk({name, "_bits"}, got, exp);
        chk({name, "_last"}, 64'(lasts), 64'(exp_last));
        chk({name, "_run"},  64'(maxrun), 64'(exp_run));
    endtask

    function automatic int count_1001();
        int c = 0;
        for (int i = 3; i < cap.size(); i++)
            if ({cap[i-3][1], cap[i-2][1], cap[i-1][1], cap[i][1]} == 4'b1001) c++;
        return c;
    endfunction

`ifdef SER_PARITY_EN
    localparam int WB = W + 1;
`else
    localparam int WB = W;
`endif

    initial begin
        logic [63:0] e;
        rst            = 1'b0;
        bus.word_valid = 1'b1;
        bus.word_in    = 8'hAA;

        // Reset held 3 cycles with a word offered.
        repeat (3) @(negedge clk);
        chk("rst_bit_out",    bus.bit_out,    1'b0);
        chk("rst_bit_valid",  bus.bit_valid,  1'b0);
        chk("rst_busy",       bus.busy,       1'b0);
        chk("rst_word_ready", bus.word_ready, 1'b0);
        rst            = 1'b1;
        bus.word_valid = 1'b0;
        @(negedge clk);
        chk("rel_word_ready", bus.word_ready, 1'b1);
        chk("rel_bit_valid",  bus.bit_valid,  1'b0);
        clear_cap();

        // Single word 8'h99.
        send(8'h99);
        wait_idle();
`ifdef SER_PARITY_EN
        e = 64'({8'h99, 1'b0});
`else
        e = 64'(8'h99);
`endif
        check_stream("w99", e, WB, 1, WB);
        chk("w99_detect", 64'(count_1001()), 64'd2);
        clear_cap();

        // Back-to-back A5, 3C, then FF stalled behind a full hold.
        send(8'hA5);
        send(8'h3C);
        send(8'hFF);
        wait_idle();
`ifdef SER_PARITY_EN
        e = 64'({8'hA5, 1'b0, 8'h3C, 1'b0, 8'hFF, 1'b0});
`else
        e = 64'({8'hA5, 8'h3C, 8'hFF});
`endif
        check_stream("b2b", e, 3 * WB, 3, 3 * WB);
        clear_cap();

        // Mid-word reset after 3 bits of 0F, with 55 parked in the hold.
        send(8'h0F);
        send(8'h55);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_bit_out",    bus.bit_out,    1'b0);
        chk("mid_bit_valid",  bus.bit_valid,  1'b0);
        chk("mid_busy",       bus.busy,       1'b0);
        check_stream("trunc", 64'h0, 3, 0, 3);
        clear_cap();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", bus.word_ready, 1'b1);
        send(8'h81);
        wait_idle();
`ifdef SER_PARITY_EN
        e = 64'({8'h81, 1'b0});
`else
        e = 64'(8'h81);
`endif
        check_stream("w81", e, WB, 1, WB);
        clear_cap();

        // 07 then 03 (parity bits 1 and 0 when enabled).
        send(8'h07);
        send(8'h03);
        wait_idle();
`ifdef SER_PARITY_EN
        e = 64'({8'h07, 1'b1, 8'h03, 1'b0});
`else
        e = 64'({8'h07, 8'h03});
`endif
        check_stream("par", e, 2 * WB, 2, 2 * WB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bit_serializer
